// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: sequential fetch, LUT-targeted branches with a
// one-cycle bubble, halt handling and saturating retire/cycle counters.
module pc_fetch_ctrl #(
    parameter int unsigned W = 10,
    parameter int unsigned A = 4
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          Jump,
    input  logic          Branch_En,
    input  logic          Cond_Flag,
    input  logic [A-1:0]  Lut_Idx,
    output logic [A-1:0]  Lut_Addr,
    input  logic [W-1:0]  Lut_Target,
    output logic [W-1:0]  PC,
    output logic          Fetch_Valid,
    output logic          Busy,
    output logic          Done,
    output logic [15:0]   Instr_Count,
    output logic [15:0]   Cycle_Count
);

    localparam int unsigned CW = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] BRANCH = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]    state_q,  state_nxt;
    logic [W-1:0]  pc_q,     pc_nxt;
    logic [CW-1:0] icnt_q,   icnt_nxt;
    logic [CW-1:0] ccnt_q,   ccnt_nxt;
    logic          fv_q,     fv_nxt;
    logic          busy_q,   busy_nxt;
    logic          done_q,   done_nxt;
    logic          branch_taken;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // LUT index goes straight through so the target is available in the same cycle
    assign Lut_Addr     = Lut_Idx;
    assign branch_taken = Jump | (Branch_En & Cond_Flag);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            icnt_q  <= '0;
            ccnt_q  <= '0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            icnt_q  <= icnt_nxt;
            ccnt_q  <= ccnt_nxt;
            fv_q    <= fv_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next-state, next-PC and counter update; status flags decode the next state
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        icnt_nxt  = icnt_q;
        ccnt_nxt  = ccnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_nxt = RUN;
                    pc_nxt    = W'(0);
                    icnt_nxt  = CW'(0);
                    ccnt_nxt  = CW'(0);
                end
            end
            RUN: begin
                ccnt_nxt = sat_inc(ccnt_q);
                icnt_nxt = sat_inc(icnt_q);
                if (Halt) begin
                    state_nxt = DONE;
                end else if (branch_taken) begin
                    state_nxt = BRANCH;
                    pc_nxt    = Lut_Target;
                end else begin
                    pc_nxt    = pc_q + W'(1);
                end
            end
            BRANCH: begin
                ccnt_nxt  = sat_inc(ccnt_q);
                state_nxt = RUN;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        fv_nxt   = (state_nxt == RUN);
        busy_nxt = (state_nxt == RUN) || (state_nxt == BRANCH);
        done_nxt = (state_nxt == DONE);
    end

    assign PC          = pc_q;
    assign Instr_Count = icnt_q;
    assign Cycle_Count = ccnt_q;
    assign Fetch_Valid = fv_q;
    assign Busy        = busy_q;
    assign Done        = done_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: stimulus queues per-edge expectations,
// a monitor pops and compares them one time unit after each rising edge.
module tb_pc_fetch_ctrl;

    localparam int unsigned W = 10;
    localparam int unsigned A = 4;

    logic          clk = 1'b0;
    logic          Reset, Start, Halt, Jump, Branch_En, Cond_Flag;
    logic [A-1:0]  Lut_Idx, Lut_Addr;
    logic [W-1:0]  Lut_Target, PC;
    logic          Fetch_Valid, Busy, Done;
    logic [15:0]   Instr_Count, Cycle_Count;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cyc      = 0;

    typedef struct packed {
        logic [31:0] at;
        logic [48:0] v;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    pc_fetch_ctrl #(.W(W), .A(A)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .Start       (Start),
        .Halt        (Halt),
        .Jump        (Jump),
        .Branch_En   (Branch_En),
        .Cond_Flag   (Cond_Flag),
        .Lut_Idx     (Lut_Idx),
        .Lut_Addr    (Lut_Addr),
        .Lut_Target  (Lut_Target),
        .PC          (PC),
        .Fetch_Valid (Fetch_Valid),
        .Busy        (Busy),
        .Done        (Done),
        .Instr_Count (Instr_Count),
        .Cycle_Count (Cycle_Count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic logic [48:0] snap_dut();
        return {PC, Fetch_Valid, Busy, Done, Instr_Count, Cycle_Count, Lut_Addr};
    endfunction

    function automatic logic [48:0] e(input logic [9:0] pc, input logic fv, input logic b,
                                      input logic d, input logic [15:0] ic, input logic [15:0] cc,
                                      input logic [3:0] la);
        return {pc, fv, b, d, ic, cc, la};
    endfunction

    task automatic chk(input string nm, input logic [48:0] got, input logic [48:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got pc=%h fv=%b busy=%b done=%b ic=%h cc=%h la=%h; want pc=%h fv=%b busy=%b done=%b ic=%h cc=%h la=%h",
                     nm, got[48:39], got[38], got[37], got[36], got[35:20], got[19:4], got[3:0],
                     want[48:39], want[38], want[37], want[36], want[35:20], want[19:4], want[3:0]);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge) and queue the post-edge expectation
    task automatic step(input string nm, input logic st, input logic h, input logic j,
                        input logic be, input logic cf, input logic [3:0] idx,
                        input logic [9:0] tgt, input logic [48:0] ev);
        exp_t t;
        Start = st; Halt = h; Jump = j; Branch_En = be; Cond_Flag = cf;
        Lut_Idx = idx; Lut_Target = tgt;
        t.at = cyc + 32'd1;
        t.v  = ev;
        exp_q.push_back(t);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        Start = 0; Halt = 0; Jump = 0; Branch_En = 0; Cond_Flag = 0;
        Lut_Idx = '0; Lut_Target = '0;
    endtask

    // Monitor: compare every expectation due at this edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                exp_t  x;
                string n;
                x = exp_q.pop_front();
                n = name_q.pop_front();
                if (x.at < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL %s: expectation for edge %0d not compared, now edge %0d", n, x.at, cyc);
                end else begin
                    chk(n, snap_dut(), x.v);
                end
            end
        end
    end

    initial begin
        int w;
        Reset = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("reset_hold", snap_dut(), e(0, 0, 0, 0, 0, 0, 0));
        Reset = 1'b1;

        step("idle_hold0", 0, 0, 0, 0, 0, 4'h0, 10'h000, e(0, 0, 0, 0, 0, 0, 0));
        step("idle_ign_jump", 0, 1, 1, 0, 0, 4'h0, 10'h155, e(0, 0, 0, 0, 0, 0, 0));
        step("start", 1, 0, 0, 0, 0, 4'h0, 10'h000, e(0, 1, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 3; k++)
            step("seq", 0, 0, 0, 0, 0, 4'h0, 10'h000, e(10'(k), 1, 1, 0, 16'(k), 16'(k), 0));
        step("jump", 0, 0, 1, 0, 0, 4'h7, 10'h155, e(10'h155, 0, 1, 0, 4, 4, 4'h7));
        step("bubble_exit", 0, 0, 0, 0, 0, 4'h0, 10'h000, e(10'h155, 1, 1, 0, 4, 5, 0));
        step("seq_start_ign", 1, 0, 0, 0, 0, 4'h0, 10'h000, e(10'h156, 1, 1, 0, 5, 6, 0));
        step("br_not_taken", 0, 0, 0, 1, 0, 4'h0, 10'h000, e(10'h157, 1, 1, 0, 6, 7, 0));
        step("br_taken", 0, 0, 0, 1, 1, 4'h3, 10'h3FF, e(10'h3FF, 0, 1, 0, 7, 8, 4'h3));
        step("branch_ign_decode", 0, 1, 1, 1, 1, 4'h5, 10'h011, e(10'h3FF, 1, 1, 0, 7, 9, 4'h5));
        step("pc_wrap", 0, 0, 0, 0, 0, 4'h0, 10'h000, e(10'h000, 1, 1, 0, 8, 10, 0));
        step("jump_20", 0, 0, 1, 0, 0, 4'h2, 10'h020, e(10'h020, 0, 1, 0, 9, 11, 4'h2));
        step("bubble_20", 0, 0, 0, 0, 0, 4'h0, 10'h000, e(10'h020, 1, 1, 0, 9, 12, 0));
        step("halt_over_jump", 0, 1, 1, 0, 0, 4'h9, 10'h099, e(10'h020, 0, 0, 1, 10, 13, 4'h9));
        step("done_hold0", 0, 1, 1, 1, 1, 4'h0, 10'h155, e(10'h020, 0, 0, 1, 10, 13, 0));
        step("done_hold1", 0, 0, 1, 0, 0, 4'h0, 10'h155, e(10'h020, 0, 0, 1, 10, 13, 0));
        step("restart", 1, 0, 0, 0, 0, 4'h0, 10'h000, e(0, 1, 1, 0, 0, 0, 0));
        step("seq_after_restart", 0, 0, 0, 0, 0, 4'h0, 10'h000, e(1, 1, 1, 0, 1, 1, 0));
        step("jump_mid", 0, 0, 1, 0, 0, 4'h1, 10'h2AA, e(10'h2AA, 0, 1, 0, 2, 2, 4'h1));

        // Now in BRANCH: reset asynchronously mid-cycle
        idle_inputs();
        #1 Reset = 1'b0;
        #1 chk("reset_in_branch", snap_dut(), e(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("reset_held", snap_dut(), e(0, 0, 0, 0, 0, 0, 0));
        Reset = 1'b1;
        step("post_reset_idle", 0, 0, 0, 0, 0, 4'h0, 10'h000, e(0, 0, 0, 0, 0, 0, 0));
        step("restart2", 1, 0, 0, 0, 0, 4'h0, 10'h000, e(0, 1, 1, 0, 0, 0, 0));
        step("seq_r1", 0, 0, 0, 0, 0, 4'h0, 10'h000, e(1, 1, 1, 0, 1, 1, 0));
        step("seq_r2", 0, 0, 0, 0, 0, 4'h0, 10'h000, e(2, 1, 1, 0, 2, 2, 0));

        // Long sequential run to push both counters past 16 bits
        idle_inputs();
        repeat (65540) @(negedge clk);
        step("saturate", 0, 0, 0, 0, 0, 4'h0, 10'h000, e(10'h007, 1, 1, 0, 16'hFFFF, 16'hFFFF, 0));
        step("halt_saturated", 0, 1, 0, 0, 0, 4'h0, 10'h000, e(10'h007, 0, 0, 1, 16'hFFFF, 16'hFFFF, 0));
        idle_inputs();

        w = 0;
        while (exp_q.size() > 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations still pending, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
